// File: rtl/alu_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu_pkg
//  Brief    : Shared op encodings, FSM states and helpers for alu_mdu.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_mdu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLTU  = 4'd8,
        OP_SRL   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    function automatic logic is_mdu_op(input alu_op_t op);
        return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu_if
//  Brief    : Request/response handshake bundle between EX-stage and alu_mdu.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    import alu_mdu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     op;
    logic [WIDTH-1:0]    src_a;
    logic [WIDTH-1:0]    src_b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    result;
    logic                zero;
    logic                busy;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu_iter
//  Brief    : One-bit-per-step shift-add multiplier / restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             mode_i,      // 1 = divide, 0 = multiply
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] prod_lo_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    // hi/lo hold {product high, product low} or {remainder, quotient}
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic             div_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   sum, rem_sh, diff;

    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        hi_d   = sum[WIDTH:1];
        lo_d   = {sum[0], lo_q[WIDTH-1:1]};
        if (div_q) begin
            if (diff[WIDTH]) begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
            div_q <= mode_i;
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Outputs present the value after the step in progress, so the parent
    // can register the final answer on the last CALC edge.
    assign prod_lo_o = lo_d;
    assign prod_hi_o = hi_d;
    assign quot_o    = lo_d;
    assign rem_o     = hi_d;

endmodule
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mdu
//  Brief    : Handshaked EX-stage ALU; ALU_MDU_MUL_DIV_EN adds iterative
//             MUL/MULHU/DIVU/REMU (otherwise ops 10-13 are reserved).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_mdu_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       state_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    alu_op_t          op_in;
    logic             accept;

    assign op_in         = alu_op_t'(bus.op);
    assign shamt         = bus.src_b[SHW-1:0];
    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);

    always_comb begin
        alu_res = '0;
        case (op_in)
            OP_ADD:  alu_res = bus.src_a + bus.src_b;
            OP_SUB:  alu_res = bus.src_a - bus.src_b;
            OP_AND:  alu_res = bus.src_a & bus.src_b;
            OP_OR:   alu_res = bus.src_a | bus.src_b;
            OP_XOR:  alu_res = bus.src_a ^ bus.src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_SLL:  alu_res = bus.src_a << shamt;
            OP_SRA:  alu_res = $signed(bus.src_a) >>> shamt;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
            OP_SRL:  alu_res = bus.src_a >> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MDU_MUL_DIV_EN
    localparam int CNT_W = SHW + 1;

    logic [CNT_W-1:0] cnt_q;
    alu_op_t          op_q;
    logic [WIDTH-1:0] prod_lo, prod_hi, quot, rem, mdu_res;

    alu_mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start_i   (accept && is_mdu_op(op_in)),
        .step_i    (state_q == CALC),
        .mode_i    (op_in inside {OP_DIVU, OP_REMU}),
        .a_i       (bus.src_a),
        .b_i       (bus.src_b),
        .prod_lo_o (prod_lo),
        .prod_hi_o (prod_hi),
        .quot_o    (quot),
        .rem_o     (rem)
    );

    always_comb begin
        mdu_res = rem;
        case (op_q)
            OP_MUL:   mdu_res = prod_lo;
            OP_MULHU: mdu_res = prod_hi;
            OP_DIVU:  mdu_res = quot;
            default:  mdu_res = rem;
        endcase
    end

    assign bus.busy = (state_q == CALC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_mdu_op(op_in)) begin
                            state_q <= CALC;
                            cnt_q   <= CNT_W'(WIDTH);
                            op_q    <= op_in;
                        end else begin
                            state_q  <= DONE;
                            result_q <= alu_res;
                        end
                    end else if (state_q == DONE && bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= DONE;
                        result_q <= mdu_res;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign bus.busy = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q  <= DONE;
                        result_q <= alu_res;
                    end else if (state_q == DONE && bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mdu
//  Brief    : Self-checking bench for alu_mdu (WIDTH = 32), reference model
//             follows ALU_MDU_MUL_DIV_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    localparam int W = 32;
`ifdef ALU_MDU_MUL_DIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_md(input logic [3:0] op);
        return MD && (op >= 4'd10) && (op <= 4'd13);
    endfunction

    // Reference behaviour from plain arithmetic
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        p  = 64'(a) * 64'(b);
        sh = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return a << sh;
            4'd7:  return 32'($signed(a) >>> sh);
            4'd8:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return a >> sh;
            4'd10: return MD ? p[31:0]  : 32'd0;
            4'd11: return MD ? p[63:32] : 32'd0;
            4'd12: return MD ? ((b == 0) ? 32'hFFFF_FFFF : a / b) : 32'd0;
            4'd13: return MD ? ((b == 0) ? a : a % b) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] res;
        int          rdy;
        bit          multi;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    bit   chk_en = 1'b0;

    // Every-cycle compare of the handshake and data outputs against the model
    always @(negedge clk) begin : mon
        bit   mv, mb, mir;
        exp_t e;
        mv  = (q.size() > 0) && (cyc >= q[0].rdy);
        mb  = (q.size() > 0) && q[0].multi && (cyc < q[0].rdy);
        mir = (q.size() == 0) || (mv && bus.out_ready);
        if (chk_en) begin
            chk("mon_out_valid", 32'(bus.out_valid), 32'(mv));
            chk("mon_in_ready",  32'(bus.in_ready),  32'(mir));
            chk("mon_busy",      32'(bus.busy),      32'(mb));
            if (mv) begin
                chk("mon_result", bus.result,       q[0].res);
                chk("mon_zero",   32'(bus.zero),    32'(q[0].res == 32'd0));
            end
        end
        if (reset) begin
            q.delete();
            chk_en = 1'b1;
        end else begin
            if (mv && bus.out_ready) void'(q.pop_front());
            if (mir && bus.in_valid) begin
                e.res   = model(bus.op, bus.src_a, bus.src_b);
                e.multi = is_md(bus.op);
                e.rdy   = cyc + (e.multi ? W + 1 : 1);
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic do_op(input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int lat, nbusy, exp_lat;
        exp_lat = is_md(op) ? W + 1 : 1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (lat <= 100) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (bus.busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_result"},  bus.result,      exp);
        chk({nm, "_zero"},    32'(bus.zero),   32'(exp == 32'd0));
        chk({nm, "_latency"}, 32'(lat),        32'(exp_lat));
        chk({nm, "_busy"},    32'(nbusy),      32'(exp_lat - 1));
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int hits;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    bus.result,         32'd0);
        chk("rst_zero",      32'(bus.zero),      32'd1);
        chk("rst_busy",      32'(bus.busy),      32'd0);

        do_op("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000);
        do_op("sub_zero", 4'd1,  32'd5,         32'd5,        32'd0);
        do_op("slt",      4'd5,  32'hFFFF_FFFF, 32'd1,        32'd1);
        do_op("sltu",     4'd8,  32'hFFFF_FFFF, 32'd1,        32'd0);
        do_op("sra",      4'd7,  32'h8000_0000, 32'h24,       32'hF800_0000);
        do_op("srl",      4'd9,  32'h8000_0000, 32'h24,       32'h0800_0000);
        do_op("sll",      4'd6,  32'd1,         32'd31,       32'h8000_0000);
        do_op("xor",      4'd4,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        do_op("rsv14",    4'd14, 32'd5,         32'd3,        32'd0);
        do_op("mul",      4'd10, 32'h1_0000,    32'h1_0000,   32'd0);
        do_op("mulhu",    4'd11, 32'h1_0000,    32'h1_0000,   MD ? 32'd1 : 32'd0);
        do_op("divu",     4'd12, 32'd100,       32'd7,        MD ? 32'd14 : 32'd0);
        do_op("remu",     4'd13, 32'd100,       32'd7,        MD ? 32'd2 : 32'd0);
        do_op("divu_z",   4'd12, 32'd123,       32'd0,        MD ? 32'hFFFF_FFFF : 32'd0);
        do_op("remu_z",   4'd13, 32'd123,       32'd0,        MD ? 32'd123 : 32'd0);

        // Backpressure: result must hold while the consumer stalls
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd0;
        bus.src_a     = 32'h1234;
        bus.src_b     = 32'd1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid",    32'(bus.out_valid), 32'd1);
            chk("hold_result",   bus.result,         32'h1235);
            chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd0;
        bus.src_a     = 32'd9;
        bus.src_b     = 32'd4;
        @(negedge clk);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("b2b_valid",  32'(bus.out_valid), 32'd1);
        chk("b2b_result", bus.result,         32'd13);

        // Reset during the tenth cycle after a multiply is accepted
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 4'd10;
        bus.src_a     = 32'd3;
        bus.src_b     = 32'd5;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy_before", 32'(bus.busy), 32'(MD));
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy",      32'(bus.busy),      32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) hits++;
        end
        chk("midrst_no_result", 32'(hits), 32'd0);

        // Randomized traffic with random consumer backpressure
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.op        = 4'($urandom_range(0, 15));
            bus.src_a     = rnd_opnd();
            bus.src_b     = rnd_opnd();
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
